// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with a shadow
// frame buffer that is committed only at the scan wrap, so frames never tear.
module seven_segment_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [7:0]              segments,
  output logic                    update_pending,
  output logic                    frame_done
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_act_data, r_sh_data;
  logic [NUM_DIGITS-1:0]   r_act_dp, r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_act_en, r_sh_en;
  logic                    r_pending;
  logic [NUM_DIGITS-1:0]   r_anodes;
  logic [7:0]              r_segments;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_wrap;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_anodes;
  logic [7:0]              w_segments;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // w_lz[k]: nibbles k..NUM_DIGITS-1 are all zero
  always_comb begin
    w_lz = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      w_lz[k] = ((r_act_data >> (4 * k)) == '0);
    end
  end

  always_comb begin
    w_anodes   = '1;
    w_segments = 8'hFF;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if ((IW'(k) == r_idx) && r_act_en[k] && !(blank_lz && (k != 0) && w_lz[k])) begin
        w_anodes[k] = 1'b0;
        w_segments  = {~r_act_dp[k], seg7(r_act_data[4*k +: 4])};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '0;
      r_sh_data    <= '0;
      r_sh_dp      <= '0;
      r_sh_en      <= '0;
      r_pending    <= 1'b0;
      r_anodes     <= '1;
      r_segments   <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      r_frame_done <= w_wrap;
      r_anodes     <= w_anodes;
      r_segments   <= w_segments;

      // Shadow is committed only when pending, so a load taken straight into
      // active at the wrap is not reverted by a stale shadow next frame.
      if (w_wrap && load) begin
        r_act_data <= data_in;
        r_act_dp   <= dp_in;
        r_act_en   <= digit_en_in;
        r_sh_data  <= data_in;
        r_sh_dp    <= dp_in;
        r_sh_en    <= digit_en_in;
        r_pending  <= 1'b0;
      end else if (w_wrap) begin
        if (r_pending) begin
          r_act_data <= r_sh_data;
          r_act_dp   <= r_sh_dp;
          r_act_en   <= r_sh_en;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_sh_data <= data_in;
        r_sh_dp   <= dp_in;
        r_sh_en   <= digit_en_in;
        r_pending <= 1'b1;
      end
    end
  end

  assign anodes         = r_anodes;
  assign segments       = r_segments;
  assign update_pending = r_pending;
  assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scoreboard bench for seven_segment_scan_driver with 4 digits, 4 cycles/digit.
module tb_seven_segment_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en_in;
  logic          blank_lz;
  logic          load;
  logic [3:0]    anodes;
  logic [7:0]    segments;
  logic          update_pending;
  logic          frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  seven_segment_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in),
    .digit_en_in(digit_en_in), .blank_lz(blank_lz), .load(load),
    .anodes(anodes), .segments(segments),
    .update_pending(update_pending), .frame_done(frame_done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_digit(input logic [3:0] an, input logic [7:0] seg);
    exp_t e;
    e.an  = an;
    e.seg = seg;
    repeat (RD) sb_q.push_back(e);
  endtask

  task automatic sb_drain_frame(input string name);
    exp_t e;
    for (int c = 0; c < 16; c++) begin
      tick();
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL %s slot %0d: scoreboard empty, got anodes=%b segments=%h", name, c, anodes, segments);
      end else begin
        e = sb_q.pop_front();
        if ({anodes, segments} !== {e.an, e.seg}) begin
          n_err++;
          $display("FAIL %s slot %0d: anodes=%b segments=%h, required anodes=%b segments=%h",
                   name, c, anodes, segments, e.an, e.seg);
        end
      end
      n_cmp++;
      if (frame_done !== 1'(c == 15)) begin
        n_err++;
        $display("FAIL %s frame_done slot %0d: got %b required %b", name, c, frame_done, (c == 15));
      end
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    data_in     = d;
    dp_in       = dp;
    digit_en_in = en;
    load        = 1'b1;
    tick();
    load        = 1'b0;
  endtask

  // Waits for frame_done, checking update_pending holds 1 beforehand and 0 after.
  task automatic wait_commit(input string name);
    int n = 0;
    bit bad = 0;
    n_cmp++;
    if (update_pending !== 1'b1) begin
      n_err++;
      $display("FAIL %s pending after load: got %b required 1", name, update_pending);
    end
    do begin
      tick();
      n++;
      if (frame_done !== 1'b1 && update_pending !== 1'b1) bad = 1;
    end while (frame_done !== 1'b1 && n < 40);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: frame_done got %b required 1 within 40 cycles", name, frame_done);
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL %s pending dropped early: got 0 required 1", name);
    end
    n_cmp++;
    if (update_pending !== 1'b0) begin
      n_err++;
      $display("FAIL %s pending at boundary: got %b required 0", name, update_pending);
    end
  endtask

  task automatic show(input string name, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    tick();
    tick();
    do_load(d, dp, en);
    wait_commit(name);
  endtask

  task automatic test_reset();
    int n = 0;
    bit dark_bad = 0;
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0;
    data_in = 16'h0; dp_in = 4'h0; digit_en_in = 4'h0;
    repeat (3) tick();
    n_cmp++;
    if ({anodes, segments, update_pending, frame_done} !== {4'b1111, 8'hFF, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset values: got an=%b seg=%h pend=%b fd=%b required 1111 ff 0 0",
               anodes, segments, update_pending, frame_done);
    end
    rst = 1'b0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    n_cmp++;
    if (frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL reset first frame_done: got %b required 1", frame_done);
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      if (anodes !== 4'b1111) dark_bad = 1;
      n_cmp++;
      if (frame_done !== 1'(c == 15)) begin
        n_err++;
        $display("FAIL reset frame period slot %0d: frame_done got %b required %b", c, frame_done, (c == 15));
      end
    end
    n_cmp++;
    if (dark_bad) begin
      n_err++;
      $display("FAIL reset dark: anodes got non-1111 required 1111");
    end
  endtask

  task automatic test_load_basic();
    show("basic", 16'h1234, 4'b0000, 4'hF);
    push_digit(4'b1110, 8'h99); push_digit(4'b1101, 8'hB0);
    push_digit(4'b1011, 8'hA4); push_digit(4'b0111, 8'hF9);
    sb_drain_frame("basic");
  endtask

  task automatic test_dp_en();
    show("dp", 16'h1234, 4'b0010, 4'hF);
    push_digit(4'b1110, 8'h99); push_digit(4'b1101, 8'h30);
    push_digit(4'b1011, 8'hA4); push_digit(4'b0111, 8'hF9);
    sb_drain_frame("dp");
    show("en", 16'h1234, 4'b0000, 4'b1011);
    push_digit(4'b1110, 8'h99); push_digit(4'b1101, 8'hB0);
    push_digit(4'b1111, 8'hFF); push_digit(4'b0111, 8'hF9);
    sb_drain_frame("en");
  endtask

  task automatic test_leading_zero();
    blank_lz = 1'b1;
    show("lz_0050", 16'h0050, 4'b0000, 4'hF);
    push_digit(4'b1110, 8'hC0); push_digit(4'b1101, 8'h92);
    push_digit(4'b1111, 8'hFF); push_digit(4'b1111, 8'hFF);
    sb_drain_frame("lz_0050");
    show("lz_0000", 16'h0000, 4'b0000, 4'hF);
    push_digit(4'b1110, 8'hC0); push_digit(4'b1111, 8'hFF);
    push_digit(4'b1111, 8'hFF); push_digit(4'b1111, 8'hFF);
    sb_drain_frame("lz_0000");
    blank_lz = 1'b0;
    show("nolz_0050", 16'h0050, 4'b0000, 4'hF);
    push_digit(4'b1110, 8'hC0); push_digit(4'b1101, 8'h92);
    push_digit(4'b1011, 8'hC0); push_digit(4'b0111, 8'hC0);
    sb_drain_frame("nolz_0050");
  endtask

  task automatic test_back_to_back();
    tick();
    tick();
    do_load(16'hAAAA, 4'b0000, 4'hF);
    tick();
    do_load(16'hBCDE, 4'b0000, 4'hF);
    wait_commit("b2b");
    push_digit(4'b1110, 8'h86); push_digit(4'b1101, 8'hA1);
    push_digit(4'b1011, 8'hC6); push_digit(4'b0111, 8'h83);
    sb_drain_frame("b2b");
  endtask

  task automatic test_wrap_load();
    bit rose = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (update_pending !== 1'b0) rose = 1;
    end
    do_load(16'h00F0, 4'b0000, 4'hF);
    n_cmp++;
    if ({frame_done, update_pending} !== 2'b10) begin
      n_err++;
      $display("FAIL wrap_load boundary: got fd=%b pend=%b required fd=1 pend=0", frame_done, update_pending);
    end
    push_digit(4'b1110, 8'hC0); push_digit(4'b1101, 8'h8E);
    push_digit(4'b1011, 8'hC0); push_digit(4'b0111, 8'hC0);
    sb_drain_frame("wrap_load");
    if (update_pending !== 1'b0) rose = 1;
    n_cmp++;
    if (rose) begin
      n_err++;
      $display("FAIL wrap_load pending: got 1 required 0 throughout");
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    tick();
    tick();
    do_load(16'h1234, 4'b0000, 4'hF);
    repeat (6) tick();
    n_cmp++;
    if ({anodes, update_pending} !== {4'b1011, 1'b1}) begin
      n_err++;
      $display("FAIL rst_mid precondition: got an=%b pend=%b required 1011 1", anodes, update_pending);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({anodes, segments, update_pending} !== {4'b1111, 8'hFF, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid: got an=%b seg=%h pend=%b required 1111 ff 0", anodes, segments, update_pending);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if ({anodes, segments, update_pending} !== {4'b1111, 8'hFF, 1'b0}) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL rst_mid stays dark: display lit or pending after reset, required dark");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_basic();
    test_dp_en();
    test_leading_zero();
    test_back_to_back();
    test_wrap_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
